// File: rtl/bin2bcd_if.sv
// Request/response bundle for the iterative binary-to-BCD converter.
// The master issues values to convert and takes results; the slave converts.
interface bin2bcd_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  signed_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  neg;

   modport master (
      output in_valid, bin_in, signed_mode, out_ready,
      input  in_ready, out_valid, bcd_out, neg
   );

   modport slave (
      input  in_valid, bin_in, signed_mode, out_ready,
      output in_ready, out_valid, bcd_out, neg
   );
endinterface

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter: one bit per clock,
// optional two's-complement input producing a sign flag plus BCD magnitude.
module bin2bcd_iter #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input logic       clk,
   input logic       rst,
   bin2bcd_if.slave  bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              capture;
   logic              last_step;

   logic [BIN_W-1:0]  mag_in;
   logic              neg_in;
   logic [BIN_W-1:0]  mag;
   logic [BIN_W-1:0]  mag_step;
   logic [BCD_W-1:0]  bcd_work;
   logic [BCD_W-1:0]  bcd_adj;
   logic [BCD_W-1:0]  bcd_step;
   logic [BCD_W-1:0]  bcd_res;
   logic              neg_work;
   logic              neg_res;
   logic [CNT_W-1:0]  cnt;

   // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int k = 0; k < DIGITS; k++) begin
         if (b[4*k +: 4] >= 4'd5)
            r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Magnitude stays unsigned BIN_W bits, so the most negative input maps to 2^(BIN_W-1).
   always_comb begin
      neg_in = bus.signed_mode & bus.bin_in[BIN_W-1];
      mag_in = neg_in ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;
   end

   always_comb begin
      bcd_adj   = dabble_adjust(bcd_work);
      bcd_step  = {bcd_adj[BCD_W-2:0], mag[BIN_W-1]};
      mag_step  = {mag[BIN_W-2:0], 1'b0};
      last_step = (cnt == CNT_W'(1));
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      capture       = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               capture   = 1'b1;
               state_nxt = CONV;
            end
         end
         CONV: begin
            if (last_step)
               state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result registers only change on the final CONV step, so they hold through IDLE/CONV.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mag      <= '0;
         bcd_work <= '0;
         neg_work <= 1'b0;
         cnt      <= '0;
         bcd_res  <= '0;
         neg_res  <= 1'b0;
      end else if (capture) begin
         mag      <= mag_in;
         neg_work <= neg_in;
         bcd_work <= '0;
         cnt      <= CNT_W'(BIN_W);
      end else if (state == CONV) begin
         mag      <= mag_step;
         bcd_work <= bcd_step;
         cnt      <= cnt - CNT_W'(1);
         if (last_step) begin
            bcd_res <= bcd_step;
            neg_res <= neg_work;
         end
      end
   end

   assign bus.bcd_out = bcd_res;
   assign bus.neg     = neg_res;
endmodule

// File: tb/tb_bin2bcd_iter.sv
// Scoreboard bench for bin2bcd_iter: an 8-bit/3-digit and a 16-bit/5-digit instance
// driven with directed vectors; monitors pop expected results as outputs appear.
module tb_bin2bcd_iter;
   localparam int BW  = 8;
   localparam int DG  = 3;
   localparam int BW2 = 16;
   localparam int DG2 = 5;

   typedef struct {
      logic [19:0] bcd;
      logic        neg;
      int          issue;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   exp_t q8[$];
   exp_t q16[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin2bcd_if #(.BIN_W(BW),  .DIGITS(DG))  bus();
   bin2bcd_if #(.BIN_W(BW2), .DIGITS(DG2)) bus16();

   bin2bcd_iter #(.BIN_W(BW),  .DIGITS(DG))  dut   (.clk(clk), .rst(rst), .bus(bus));
   bin2bcd_iter #(.BIN_W(BW2), .DIGITS(DG2)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endfunction

   // Monitors: on each rising out_valid, pop the oldest expectation and compare.
   logic pv8 = 1'b0;
   exp_t e8;
   always @(negedge clk) begin
      if (!rst) begin
         pv8 = 1'b0;
      end else begin
         if (bus.out_valid && !pv8) begin
            if (q8.size() == 0) begin
               check("unexpected_out8", 32'd1, 32'd0);
            end else begin
               e8 = q8.pop_front();
               check("bcd8", 32'(bus.bcd_out), 32'(e8.bcd));
               check("neg8", 32'(bus.neg), 32'(e8.neg));
               check("latency8", cyc, e8.issue + BW + 1);
            end
         end
         pv8 = bus.out_valid;
      end
   end

   logic pv16 = 1'b0;
   exp_t e16;
   always @(negedge clk) begin
      if (!rst) begin
         pv16 = 1'b0;
      end else begin
         if (bus16.out_valid && !pv16) begin
            if (q16.size() == 0) begin
               check("unexpected_out16", 32'd1, 32'd0);
            end else begin
               e16 = q16.pop_front();
               check("bcd16", 32'(bus16.bcd_out), 32'(e16.bcd));
               check("neg16", 32'(bus16.neg), 32'(e16.neg));
               check("latency16", cyc, e16.issue + BW2 + 1);
            end
         end
         pv16 = bus16.out_valid;
      end
   end

   // Present a request once in_ready is seen; leaves in_valid high for the caller to drop.
   task automatic send8(input logic [7:0] b, input logic sm, input logic [11:0] eb,
                        input logic en, input bit push, output int ic);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("in_ready_timeout8", 32'd0, 32'd1);
      bus.in_valid    = 1'b1;
      bus.bin_in      = b;
      bus.signed_mode = sm;
      ic = cyc;
      if (push) q8.push_back('{bcd: {8'h00, eb}, neg: en, issue: cyc});
   endtask

   task automatic send16(input logic [15:0] b, input logic sm, input logic [19:0] eb, input logic en);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus16.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus16.in_ready) check("in_ready_timeout16", 32'd0, 32'd1);
      bus16.in_valid    = 1'b1;
      bus16.bin_in      = b;
      bus16.signed_mode = sm;
      q16.push_back('{bcd: eb, neg: en, issue: cyc});
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
   endtask

   task automatic drop8();
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q8.size() != 0 || q16.size() != 0 || !bus.in_ready || !bus16.in_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(q8.size() + q16.size()), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int ic, ic_prev, n;
      bus.in_valid      = 1'b0;
      bus.bin_in        = '0;
      bus.signed_mode   = 1'b0;
      bus.out_ready     = 1'b0;
      bus16.in_valid    = 1'b0;
      bus16.bin_in      = '0;
      bus16.signed_mode = 1'b0;
      bus16.out_ready   = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_bcd_out",   32'(bus.bcd_out), 32'd0);
      check("rst_neg",       32'(bus.neg), 32'd0);
      rst = 1'b1;
      bus.out_ready = 1'b1;

      // Single conversions, unsigned and signed, including boundaries
      send8(8'hFF, 1'b0, 12'h255, 1'b0, 1'b1, ic); drop8();
      send8(8'h80, 1'b1, 12'h128, 1'b1, 1'b1, ic); drop8();
      send8(8'h80, 1'b0, 12'h128, 1'b0, 1'b1, ic); drop8();
      send8(8'hF6, 1'b1, 12'h010, 1'b1, 1'b1, ic); drop8();
      send8(8'h00, 1'b1, 12'h000, 1'b0, 1'b1, ic); drop8();
      send8(8'h00, 1'b0, 12'h000, 1'b0, 1'b1, ic); drop8();
      send8(8'h7F, 1'b1, 12'h127, 1'b0, 1'b1, ic); drop8();
      send8(8'hFF, 1'b1, 12'h001, 1'b1, 1'b1, ic); drop8();
      send8(8'h9C, 1'b0, 12'h156, 1'b0, 1'b1, ic); drop8();
      drain();

      // Back-pressure in DONE: result must hold while inputs wiggle
      bus.out_ready = 1'b0;
      send8(8'h39, 1'b0, 12'h057, 1'b0, 1'b1, ic); drop8();
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_reach_done", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_bcd_out",   32'(bus.bcd_out), 32'h057);
         check("hold_neg",       32'(bus.neg), 32'd0);
         check("hold_in_ready",  32'(bus.in_ready), 32'd0);
         bus.in_valid    = ~bus.in_valid;
         bus.bin_in      = 8'(i * 37 + 5);
         bus.signed_mode = ~bus.signed_mode;
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("release_out_valid", 32'(bus.out_valid), 32'd0);
      check("release_in_ready",  32'(bus.in_ready), 32'd1);
      check("release_bcd_held",  32'(bus.bcd_out), 32'h057);

      // Reset in the 4th CONV cycle aborts without a result
      send8(8'h63, 1'b0, 12'h099, 1'b0, 1'b0, ic);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort_in_ready",  32'(bus.in_ready), 32'd1);
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_bcd_out",   32'(bus.bcd_out), 32'd0);
      check("abort_neg",       32'(bus.neg), 32'd0);
      send8(8'h2A, 1'b0, 12'h042, 1'b0, 1'b1, ic); drop8();
      drain();

      // Streaming with in_valid and out_ready held high
      send8(8'd0,   1'b0, 12'h000, 1'b0, 1'b1, ic);
      ic_prev = ic;
      send8(8'd1,   1'b0, 12'h001, 1'b0, 1'b1, ic);
      check("stream_spacing1", ic - ic_prev, 32'd10);
      ic_prev = ic;
      send8(8'd99,  1'b0, 12'h099, 1'b0, 1'b1, ic);
      check("stream_spacing2", ic - ic_prev, 32'd10);
      ic_prev = ic;
      send8(8'd200, 1'b0, 12'h200, 1'b0, 1'b1, ic);
      check("stream_spacing3", ic - ic_prev, 32'd10);
      drop8();
      drain();

      // Wide configuration
      send16(16'hFFFF, 1'b0, 20'h65535, 1'b0);
      send16(16'h8000, 1'b1, 20'h32768, 1'b1);
      send16(16'h8000, 1'b0, 20'h32768, 1'b0);
      send16(16'hFC18, 1'b1, 20'h01000, 1'b1);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
